// File: rtl/lane_ctrl_pkg.sv
// Shared types and constants for the four-lane traffic phase sequencer.
package lane_ctrl_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

endpackage

// File: rtl/lane_phase_controller_if.sv
// Sensor inputs and lamp outputs of the lane phase controller.
// The emergency preemption signals exist only when EMERG_PREEMPT_EN is defined.
interface lane_phase_controller_if;
    logic [3:0] lane_req;
`ifdef EMERG_PREEMPT_EN
    logic       emerg_req;
    logic [1:0] emerg_lane;
`endif
    logic [1:0] cur_lane;
    logic [1:0] phase;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;

    modport master (
        output lane_req,
`ifdef EMERG_PREEMPT_EN
        output emerg_req,
        output emerg_lane,
`endif
        input  cur_lane,
        input  phase,
        input  green,
        input  yellow,
        input  red
    );

    modport slave (
        input  lane_req,
`ifdef EMERG_PREEMPT_EN
        input  emerg_req,
        input  emerg_lane,
`endif
        output cur_lane,
        output phase,
        output green,
        output yellow,
        output red
    );
endinterface

// File: rtl/rr_lane_pick.sv
// Round-robin next-lane pick: first requesting lane after cur_lane, wrapping mod 4.
module rr_lane_pick
    import lane_ctrl_pkg::*;
(
    input  logic [NUM_LANES-1:0] lane_req_i,
    input  lane_t                cur_lane_i,
    output lane_t                pick_o,
    output logic                 other_req_o
);

    lane_t cand;

    // Scan from the farthest lane down so the nearest requester wins.
    always_comb begin
        pick_o      = cur_lane_i;
        other_req_o = 1'b0;
        cand        = cur_lane_i;
        for (int k = 3; k >= 1; k--) begin
            cand = cur_lane_i + lane_t'(k);
            if (lane_req_i[cand]) begin
                pick_o      = cand;
                other_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_phase_controller.sv
// Four-lane GREEN/YELLOW/ALL_RED phase sequencer with round-robin lane choice.
// Optional emergency preemption is enabled by defining EMERG_PREEMPT_EN.
module lane_phase_controller
    import lane_ctrl_pkg::*;
#(
    parameter int unsigned MIN_GREEN = 3,
    parameter int unsigned MAX_GREEN = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    lane_phase_controller_if.slave  bus_io
);

    localparam int unsigned TimerW = ($clog2(MAX_GREEN + 1) > 0) ? $clog2(MAX_GREEN + 1) : 1;

    localparam logic [TimerW-1:0] MinLast = TimerW'(MIN_GREEN - 1);
    localparam logic [TimerW-1:0] MaxLast = TimerW'(MAX_GREEN - 1);
    localparam logic [TimerW-1:0] MaxSat  = TimerW'(MAX_GREEN);
    localparam logic [TimerW-1:0] YelLast = TimerW'(YELLOW_T - 1);
    localparam logic [TimerW-1:0] ArLast  = TimerW'(ALLRED_T - 1);

    phase_e            phase_q, phase_d;
    lane_t             cur_lane_q, cur_lane_d;
    lane_t             pend_lane_q, pend_lane_d;
    logic [TimerW-1:0] timer_q, timer_d;

    lane_t pick;
    logic  other_req;
    logic  green_exit;
    lane_t next_pend;

    rr_lane_pick u_pick (
        .lane_req_i  (bus_io.lane_req),
        .cur_lane_i  (cur_lane_q),
        .pick_o      (pick),
        .other_req_o (other_req)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q     <= PH_GREEN;
            cur_lane_q  <= '0;
            pend_lane_q <= '0;
            timer_q     <= '0;
        end else begin
            phase_q     <= phase_d;
            cur_lane_q  <= cur_lane_d;
            pend_lane_q <= pend_lane_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        cur_lane_d  = cur_lane_q;
        pend_lane_d = pend_lane_q;
        timer_d     = timer_q;
        green_exit  = (timer_q >= MinLast) && other_req &&
                      (!bus_io.lane_req[cur_lane_q] || (timer_q >= MaxLast));
        next_pend   = pick;
`ifdef EMERG_PREEMPT_EN
        // Preemption overrides the timing rules; a request for the current lane pins green.
        if (bus_io.emerg_req) begin
            green_exit = (bus_io.emerg_lane != cur_lane_q);
            next_pend  = bus_io.emerg_lane;
        end
`endif
        case (phase_q)
            PH_GREEN: begin
                timer_d = (timer_q == MaxSat) ? timer_q : timer_q + TimerW'(1);
                if (green_exit) begin
                    pend_lane_d = next_pend;
                    phase_d     = PH_YELLOW;
                    timer_d     = '0;
                end
            end
            PH_YELLOW: begin
                timer_d = timer_q + TimerW'(1);
`ifdef EMERG_PREEMPT_EN
                if (bus_io.emerg_req) pend_lane_d = bus_io.emerg_lane;
`endif
                if (timer_q == YelLast) begin
                    phase_d = PH_ALLRED;
                    timer_d = '0;
                end
            end
            PH_ALLRED: begin
                timer_d = timer_q + TimerW'(1);
`ifdef EMERG_PREEMPT_EN
                if (bus_io.emerg_req) pend_lane_d = bus_io.emerg_lane;
`endif
                if (timer_q == ArLast) begin
                    phase_d    = PH_GREEN;
                    cur_lane_d = pend_lane_q;
                    timer_d    = '0;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                timer_d = '0;
            end
        endcase
    end

    logic [3:0] green_w, yellow_w;

    assign green_w         = (phase_q == PH_GREEN)  ? (4'b0001 << cur_lane_q) : 4'b0000;
    assign yellow_w        = (phase_q == PH_YELLOW) ? (4'b0001 << cur_lane_q) : 4'b0000;
    assign bus_io.green    = green_w;
    assign bus_io.yellow   = yellow_w;
    assign bus_io.red      = ~(green_w | yellow_w);
    assign bus_io.phase    = phase_q;
    assign bus_io.cur_lane = cur_lane_q;

endmodule

// File: tb/tb_lane_phase_controller.sv
// Scoreboard bench for lane_phase_controller with directed, hand-computed vectors.
module tb_lane_phase_controller;

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] lane;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
    } exp_t;

    localparam logic [1:0] PG = 2'b00;
    localparam logic [1:0] PY = 2'b01;
    localparam logic [1:0] PR = 2'b10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc_n;
    exp_t exp_q[$];

    lane_phase_controller_if bus ();

    lane_phase_controller u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
    initial begin
        exp_t e;
        exp_t a;
        cyc_n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus.phase, bus.cur_lane, bus.green, bus.yellow, bus.red};
                checks++;
                cyc_n++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL state vec%0d got ph=%b lane=%0d g=%b y=%b r=%b want ph=%b lane=%0d g=%b y=%b r=%b",
                             cyc_n, a.ph, a.lane, a.g, a.y, a.r, e.ph, e.lane, e.g, e.y, e.r);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic [3:0] req, input logic [1:0] ph,
                       input logic [1:0] lane, input logic [3:0] g, input logic [3:0] y);
        exp_t e;
        reset        = rst;
        bus.lane_req = req;
        e = '{ph, lane, g, y, ~(g | y)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n, input logic [3:0] req, input logic [1:0] ph,
                        input logic [1:0] lane, input logic [3:0] g, input logic [3:0] y);
        for (int i = 0; i < n; i++) cyc(1'b0, req, ph, lane, g, y);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.lane_req = 4'b0000;
`ifdef EMERG_PREEMPT_EN
        bus.emerg_req  = 1'b0;
        bus.emerg_lane = 2'd0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.lane_req = 4'b0000;
`ifdef EMERG_PREEMPT_EN
        bus.emerg_req  = 1'b0;
        bus.emerg_lane = 2'd0;
`endif
        @(posedge clk);
        #1;

        // Idle: lane 0 green forever
        do_reset();
        cycn(20, 4'b0000, PG, 2'd0, 4'b0001, 4'b0000);

        // Single request on lane 2: minimum green then change
        do_reset();
        cycn(3, 4'b0100, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b0100, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b0100, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(3, 4'b0100, PG, 2'd2, 4'b0100, 4'b0000);

        // Current lane also requesting: maximum green
        do_reset();
        cycn(8, 4'b1001, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b1001, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b1001, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(2, 4'b1001, PG, 2'd3, 4'b1000, 4'b0000);

        // Wrap-around from lane 3 to lane 0
        do_reset();
        cycn(3, 4'b1000, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b1000, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b1000, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(3, 4'b0011, PG, 2'd3, 4'b1000, 4'b0000);
        cycn(2, 4'b0011, PY, 2'd3, 4'b0000, 4'b1000);
        cycn(1, 4'b0011, PR, 2'd3, 4'b0000, 4'b0000);
        cycn(1, 4'b0011, PG, 2'd0, 4'b0001, 4'b0000);

        // From lane 1 with 1001 the nearest requester is lane 3
        do_reset();
        cycn(3, 4'b0010, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b0010, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b0010, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(3, 4'b1001, PG, 2'd1, 4'b0010, 4'b0000);
        cycn(2, 4'b1001, PY, 2'd1, 4'b0000, 4'b0010);
        cycn(1, 4'b1001, PR, 2'd1, 4'b0000, 4'b0000);
        cycn(1, 4'b1001, PG, 2'd3, 4'b1000, 4'b0000);

        // Request dropped during yellow: change still completes
        do_reset();
        cycn(3, 4'b0010, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b0000, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b0000, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(3, 4'b0000, PG, 2'd1, 4'b0010, 4'b0000);

        // Reset during all-red, then minimum green again proves timer restarted at 0
        do_reset();
        cycn(3, 4'b0100, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b0100, PY, 2'd0, 4'b0000, 4'b0001);
        cyc(1'b1, 4'b0100, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(3, 4'b0100, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(1, 4'b0100, PY, 2'd0, 4'b0000, 4'b0001);

`ifdef EMERG_PREEMPT_EN
        // Emergency preemption to lane 2 at timer 1, then held request pins lane 2
        do_reset();
        cycn(1, 4'b0000, PG, 2'd0, 4'b0001, 4'b0000);
        bus.emerg_req  = 1'b1;
        bus.emerg_lane = 2'd2;
        cycn(1, 4'b0000, PG, 2'd0, 4'b0001, 4'b0000);
        cycn(2, 4'b0000, PY, 2'd0, 4'b0000, 4'b0001);
        cycn(1, 4'b0000, PR, 2'd0, 4'b0000, 4'b0000);
        cycn(12, 4'b0001, PG, 2'd2, 4'b0100, 4'b0000);
        bus.emerg_req = 1'b0;
`endif

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
